// File: rtl/cpu_run_ctrl_pkg.sv
// Shared state encodings and datapath widths for the run/step controller.
package cpu_run_pkg;

   localparam int DIV_W   = 24;
   localparam int BURST_W = 16;
   localparam int CNT_W   = 32;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_STEP   = 3'd1,
      ST_RUN    = 3'd2,
      ST_BURST  = 3'd3,
      ST_HALTED = 3'd4
   } run_state_e;

endpackage

// File: rtl/cpu_run_ctrl_edge_rise.sv
// Rising-edge detector for a debounced key; prev resets high so a key held
// through reset never produces a spurious edge.
module edge_rise (
   input  logic clk,
   input  logic rst,
   input  logic d,
   output logic rise
);

   logic prev_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         prev_q <= 1'b1;
      end else begin
         prev_q <= d;
      end
   end

   assign rise = d & ~prev_q;

endmodule

// File: rtl/cpu_run_ctrl.sv
// Run/step controller: turns front-panel key edges into a registered cpu_en
// pulse stream (single step, divided free-run, fixed burst) and counts pulses.
module cpu_run_ctrl
   import cpu_run_pkg::*;
#(
   parameter int unsigned RUN_DIV = 4,
   parameter int unsigned BURST_N = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              key_step,
   input  logic              key_run,
   input  logic              key_burst,
   input  logic              halt_i,
   output logic              cpu_en,
   output logic [2:0]        state_o,
   output logic [CNT_W-1:0]  cycle_cnt
);

   localparam logic [DIV_W-1:0]   DIV_LAST   = DIV_W'(RUN_DIV - 1);
   localparam logic [BURST_W-1:0] BURST_INIT = BURST_W'(BURST_N);

   run_state_e         state_q, state_d;
   logic [DIV_W-1:0]   div_q, div_d;
   logic [BURST_W-1:0] rem_q, rem_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic               en_q, en_d;

   logic stepRise, runRise, burstRise;
   logic divLast;

   edge_rise u_step  (.clk(clk), .rst(rst), .d(key_step),  .rise(stepRise));
   edge_rise u_run   (.clk(clk), .rst(rst), .d(key_run),   .rise(runRise));
   edge_rise u_burst (.clk(clk), .rst(rst), .d(key_burst), .rise(burstRise));

   assign divLast = (div_q == DIV_LAST);

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         div_q   <= '0;
         rem_q   <= '0;
         cnt_q   <= '0;
         en_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         div_q   <= div_d;
         rem_q   <= rem_d;
         cnt_q   <= cnt_d;
         en_q    <= en_d;
      end
   end

   // Halt is applied last so it overrides any pulse or transition decided above.
   always_comb begin
      state_d = state_q;
      div_d   = div_q;
      rem_d   = rem_q;
      en_d    = 1'b0;

      unique case (state_q)
         ST_IDLE: begin
            if (stepRise) begin
               state_d = ST_STEP;
               en_d    = 1'b1;
            end else if (runRise) begin
               state_d = ST_RUN;
               div_d   = '0;
            end else if (burstRise) begin
               state_d = ST_BURST;
               div_d   = '0;
               rem_d   = BURST_INIT;
            end
         end
         ST_STEP: begin
            state_d = ST_IDLE;
         end
         ST_RUN: begin
            if (runRise) begin
               state_d = ST_IDLE;
            end else begin
               div_d = divLast ? '0 : div_q + 1'b1;
               en_d  = divLast;
            end
         end
         ST_BURST: begin
            if (runRise) begin
               state_d = ST_IDLE;
            end else begin
               div_d = divLast ? '0 : div_q + 1'b1;
               if (divLast) begin
                  en_d  = 1'b1;
                  rem_d = rem_q - 1'b1;
                  if (rem_q == BURST_W'(1)) begin
                     state_d = ST_IDLE;
                  end
               end
            end
         end
         ST_HALTED: begin
            state_d = ST_HALTED;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      if (halt_i && (state_q != ST_HALTED)) begin
         state_d = ST_HALTED;
         en_d    = 1'b0;
      end
   end

   assign cnt_d     = cnt_q + CNT_W'(en_d);
   assign cpu_en    = en_q;
   assign state_o   = state_q;
   assign cycle_cnt = cnt_q;

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// Directed bench for cpu_run_ctrl: a vector table for reset/step/priority
// behaviour plus hand-written run, burst, halt and counter-wrap sequences.
module tb_cpu_run_ctrl;

   localparam int RUN_DIV = 4;
   localparam int BURST_N = 8;

   logic        clk;
   logic        rst;
   logic        keyStep;
   logic        keyRun;
   logic        keyBurst;
   logic        haltIn;
   logic        cpuEn;
   logic [2:0]  stateOut;
   logic [31:0] cycleCnt;

   int nCompared   = 0;
   int nMismatched = 0;

   typedef struct {
      logic        step;
      logic        run;
      logic        burst;
      logic        halt;
      logic        rst;
      logic        expEn;
      logic [2:0]  expSt;
      logic [31:0] expCnt;
   } vec_t;

   vec_t vecs[$];

   cpu_run_ctrl #(.RUN_DIV(RUN_DIV), .BURST_N(BURST_N)) dut (
      .clk       (clk),
      .rst       (rst),
      .key_step  (keyStep),
      .key_run   (keyRun),
      .key_burst (keyBurst),
      .halt_i    (haltIn),
      .cpu_en    (cpuEn),
      .state_o   (stateOut),
      .cycle_cnt (cycleCnt)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   function automatic void addVec(logic s, logic r, logic b, logic h, logic rs,
                                  logic en, logic [2:0] st, logic [31:0] cnt);
      vec_t v;
      v.step = s; v.run = r; v.burst = b; v.halt = h; v.rst = rs;
      v.expEn = en; v.expSt = st; v.expCnt = cnt;
      vecs.push_back(v);
   endfunction

   // Drive inputs away from the edge, clock once, then settle past the edge.
   task automatic applyStimulus(input logic s, input logic r, input logic b,
                                input logic h, input logic rs);
      @(negedge clk);
      keyStep  = s;
      keyRun   = r;
      keyBurst = b;
      haltIn   = h;
      rst      = rs;
      @(posedge clk);
      #1;
   endtask

   task automatic checkOutput(input string name, input logic expEn,
                              input logic [2:0] expSt, input logic [31:0] expCnt);
      nCompared++;
      if (cpuEn !== expEn) begin
         nMismatched++;
         $display("[TB] FAIL %s cpu_en: got %b expected %b", name, cpuEn, expEn);
      end
      nCompared++;
      if (stateOut !== expSt) begin
         nMismatched++;
         $display("[TB] FAIL %s state_o: got %0d expected %0d", name, stateOut, expSt);
      end
      nCompared++;
      if (cycleCnt !== expCnt) begin
         nMismatched++;
         $display("[TB] FAIL %s cycle_cnt: got %h expected %h", name, cycleCnt, expCnt);
      end
   endtask

   // Two reset cycles, then one idle cycle so every prev register drops low.
   task automatic doReset();
      applyStimulus(0, 0, 0, 0, 1);
      applyStimulus(0, 0, 0, 0, 1);
      applyStimulus(0, 0, 0, 0, 0);
      checkOutput("reset", 1'b0, 3'd0, 32'd0);
   endtask

   initial begin
      int expCnt;
      int rem;
      logic [2:0] expSt;
      logic expEn;

      keyStep = 0; keyRun = 0; keyBurst = 0; haltIn = 0; rst = 1;

      // Reset with run held high, then hold it: no edge may appear.
      addVec(0, 1, 0, 0, 1, 0, 3'd0, 32'd0);
      addVec(0, 1, 0, 0, 1, 0, 3'd0, 32'd0);
      for (int i = 0; i < 20; i++) addVec(0, 1, 0, 0, 0, 0, 3'd0, 32'd0);
      addVec(0, 0, 0, 0, 0, 0, 3'd0, 32'd0);
      // Single step, held key gives no second pulse.
      addVec(1, 0, 0, 0, 0, 1, 3'd1, 32'd1);
      addVec(1, 0, 0, 0, 0, 0, 3'd0, 32'd1);
      addVec(0, 0, 0, 0, 0, 0, 3'd0, 32'd1);
      // Run edge arriving while in STEP is discarded.
      addVec(1, 0, 0, 0, 0, 1, 3'd1, 32'd2);
      addVec(0, 1, 0, 0, 0, 0, 3'd0, 32'd2);
      addVec(0, 1, 0, 0, 0, 0, 3'd0, 32'd2);
      addVec(0, 0, 0, 0, 0, 0, 3'd0, 32'd2);
      // All three edges together: step wins.
      addVec(1, 1, 1, 0, 0, 1, 3'd1, 32'd3);
      addVec(1, 1, 1, 0, 0, 0, 3'd0, 32'd3);
      addVec(0, 0, 0, 0, 0, 0, 3'd0, 32'd3);
      // Run beats burst, then run edge stops before any pulse.
      addVec(0, 1, 1, 0, 0, 0, 3'd2, 32'd3);
      addVec(0, 0, 0, 0, 0, 0, 3'd2, 32'd3);
      addVec(0, 1, 0, 0, 0, 0, 3'd0, 32'd3);
      addVec(0, 0, 0, 0, 0, 0, 3'd0, 32'd3);

      foreach (vecs[i]) begin
         applyStimulus(vecs[i].step, vecs[i].run, vecs[i].burst, vecs[i].halt, vecs[i].rst);
         checkOutput($sformatf("vec%0d", i), vecs[i].expEn, vecs[i].expSt, vecs[i].expCnt);
      end

      // Free run for 42 cycles: pulses at t0+4k, then stop edge.
      doReset();
      applyStimulus(0, 1, 0, 0, 0);
      checkOutput("run_start", 1'b0, 3'd2, 32'd0);
      expCnt = 0;
      for (int i = 1; i <= 42; i++) begin
         expEn = ((i % RUN_DIV) == 0);
         if (expEn) expCnt++;
         applyStimulus(0, 0, 0, 0, 0);
         checkOutput($sformatf("run_c%0d", i), expEn, 3'd2, 32'(expCnt));
      end
      applyStimulus(0, 1, 0, 0, 0);
      checkOutput("run_stop", 1'b0, 3'd0, 32'd10);
      for (int i = 0; i < 6; i++) begin
         applyStimulus(0, 0, 0, 0, 0);
         checkOutput("run_after", 1'b0, 3'd0, 32'd10);
      end

      // Full burst of BURST_N pulses, last pulse returns to IDLE.
      doReset();
      applyStimulus(0, 0, 1, 0, 0);
      checkOutput("burst_start", 1'b0, 3'd3, 32'd0);
      rem = BURST_N; expCnt = 0; expSt = 3'd3;
      for (int i = 1; i <= 40; i++) begin
         expEn = 1'b0;
         if (expSt == 3'd3 && (i % RUN_DIV) == 0) begin
            expEn = 1'b1;
            expCnt++;
            rem--;
            if (rem == 0) expSt = 3'd0;
         end
         applyStimulus(0, 0, 0, 0, 0);
         checkOutput($sformatf("burst_c%0d", i), expEn, expSt, 32'(expCnt));
      end

      // Burst aborted by run edge after the third pulse.
      doReset();
      applyStimulus(0, 0, 1, 0, 0);
      checkOutput("abort_start", 1'b0, 3'd3, 32'd0);
      expCnt = 0;
      for (int i = 1; i <= 13; i++) begin
         expEn = ((i % RUN_DIV) == 0);
         if (expEn) expCnt++;
         applyStimulus(0, 0, 0, 0, 0);
         checkOutput($sformatf("abort_c%0d", i), expEn, 3'd3, 32'(expCnt));
      end
      applyStimulus(0, 1, 0, 0, 0);
      checkOutput("abort_stop", 1'b0, 3'd0, 32'd3);
      applyStimulus(0, 0, 0, 0, 0);
      checkOutput("abort_after1", 1'b0, 3'd0, 32'd3);
      applyStimulus(0, 0, 0, 0, 0);
      checkOutput("abort_after2", 1'b0, 3'd0, 32'd3);

      // Halt on the cycle a run pulse is due; only reset leaves HALTED.
      doReset();
      applyStimulus(1, 0, 0, 0, 0);
      checkOutput("halt_step", 1'b1, 3'd1, 32'd1);
      applyStimulus(0, 0, 0, 0, 0);
      checkOutput("halt_idle", 1'b0, 3'd0, 32'd1);
      applyStimulus(0, 1, 0, 0, 0);
      checkOutput("halt_run", 1'b0, 3'd2, 32'd1);
      for (int i = 1; i <= 3; i++) begin
         applyStimulus(0, 0, 0, 0, 0);
         checkOutput("halt_wait", 1'b0, 3'd2, 32'd1);
      end
      applyStimulus(0, 0, 0, 1, 0);
      checkOutput("halt_due", 1'b0, 3'd4, 32'd1);
      applyStimulus(1, 0, 0, 0, 0);
      checkOutput("halt_key_step", 1'b0, 3'd4, 32'd1);
      applyStimulus(0, 1, 0, 0, 0);
      checkOutput("halt_key_run", 1'b0, 3'd4, 32'd1);
      applyStimulus(0, 0, 1, 0, 0);
      checkOutput("halt_key_burst", 1'b0, 3'd4, 32'd1);
      for (int i = 0; i < 5; i++) begin
         applyStimulus(0, 0, 0, 0, 0);
         checkOutput("halt_hold", 1'b0, 3'd4, 32'd1);
      end
      applyStimulus(0, 0, 0, 0, 1);
      checkOutput("halt_rst", 1'b0, 3'd0, 32'd0);
      applyStimulus(0, 0, 0, 0, 0);
      checkOutput("halt_rst_idle", 1'b0, 3'd0, 32'd0);

      // Counter wrap: preload near the top, then three single steps.
      doReset();
      @(negedge clk);
      force dut.cnt_q = 32'hFFFF_FFFE;
      #1;
      release dut.cnt_q;
      #1;
      checkOutput("wrap_preload", 1'b0, 3'd0, 32'hFFFF_FFFE);
      applyStimulus(1, 0, 0, 0, 0);
      checkOutput("wrap_s1", 1'b1, 3'd1, 32'hFFFF_FFFF);
      applyStimulus(0, 0, 0, 0, 0);
      checkOutput("wrap_s1_idle", 1'b0, 3'd0, 32'hFFFF_FFFF);
      applyStimulus(1, 0, 0, 0, 0);
      checkOutput("wrap_s2", 1'b1, 3'd1, 32'h0000_0000);
      applyStimulus(0, 0, 0, 0, 0);
      checkOutput("wrap_s2_idle", 1'b0, 3'd0, 32'h0000_0000);
      applyStimulus(1, 0, 0, 0, 0);
      checkOutput("wrap_s3", 1'b1, 3'd1, 32'h0000_0001);
      applyStimulus(0, 0, 0, 0, 0);
      checkOutput("wrap_s3_idle", 1'b0, 3'd0, 32'h0000_0001);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
      $finish;
   end

endmodule

// File: doc/cpu_run_ctrl.md
# cpu_run_ctrl

Run/step controller for the single-cycle MIPS board build. Takes the debounced front-panel keys (step, run, burst) and the CPU's halt flag, and produces a one-cycle clock-enable pulse stream, `cpu_en`, that sequences the CPU datapath. Supported modes are single-step, free-run at a divided rate, and a fixed-length burst. It also keeps a retired-cycle count for the display logic.

## Interface
- `RUN_DIV`, default 4: cycles between `cpu_en` pulses in RUN and BURST; legal range 1..2^24-1.
- `BURST_N`, default 8: number of `cpu_en` pulses per burst; legal range 1..2^16-1.
- `clk`  in  1  system clock; one clock domain for the whole block.
- `rst`  in  1  reset; synchronous, active-high.
- `key_step`  in  1  debounced step key, level, active-high.
- `key_run`  in  1  debounced run/stop toggle key, level, active-high.
- `key_burst`  in  1  debounced burst key, level, active-high.
- `halt_i`  in  1  CPU halt request, level.
- `cpu_en`  out  1  registered datapath enable; each high cycle is exactly one CPU cycle.
- `state_o`  out  3  current FSM state encoding, for LEDs.
- `cycle_cnt`  out  32  count of `cpu_en` pulses issued.

## Operation
- Each key has a rising-edge detector: `edge = level & ~prev`. The `prev` register resets to 1, so a key held through reset gives no edge.
- FSM states and encodings: IDLE=0, STEP=1, RUN=2, BURST=3, HALTED=4.
- `halt_i`=1 has top priority in every state except HALTED:
  - next state is HALTED;
  - `cpu_en` <= 0.
- HALTED is left only by `rst`.
- IDLE, edge priority when several edges arrive together: step > run > burst.
  - step edge -> STEP, `cpu_en` <= 1.
  - run edge -> RUN, divider <= 0.
  - burst edge -> BURST, divider <= 0, remaining <= `BURST_N`.
- STEP: lasts one cycle, then IDLE unconditionally; `cpu_en` <= 0. Edges seen in STEP are discarded.
- RUN:
  - The divider counts 0..`RUN_DIV`-1 and wraps.
  - `cpu_en` <= 1 in the cycle where divider==`RUN_DIV`-1, else 0.
  - run edge -> IDLE, `cpu_en` <= 0. Stop beats a pulse due in the same cycle.
  - step and burst edges are ignored.
- BURST:
  - Pulse timing is the same as RUN; each pulse decrements remaining.
  - The pulse that takes remaining from 1 to 0 also moves the FSM to IDLE.
  - run edge aborts to IDLE with no pulse.
- `cycle_cnt` increments by 1 on every cycle where `cpu_en` is registered to 1. It wraps 2^32-1 -> 0.
- `RUN_DIV`=1 gives `cpu_en` continuously high in RUN; a burst is then `BURST_N` consecutive cycles.

## Timing
- Reset values: FSM=IDLE, `cpu_en`=0, `state_o`=0, `cycle_cnt`=0, divider=0, remaining=0, all `prev`=1.
- Step latency: the key is sampled high (prev low) at posedge t0, and `cpu_en` is high for exactly the cycle t0..t1.
- Run: if the run edge is sampled at t0, the first pulse is high during cycle t0+`RUN_DIV`..t0+`RUN_DIV`+1. Pulses then repeat with period `RUN_DIV`.
- `halt_i` sampled high at posedge t forces `cpu_en`=0 from t onward, including a pulse that was due at t.
- `rst` high at any posedge overrides everything, including mid-burst and mid-run. Its effect is visible in the following cycle.
- `state_o` follows the FSM register with zero added latency.

## Structure
- Shared package `cpu_run_pkg`:
  - state encodings;
  - widths DIV_W=24, BURST_W=16, CNT_W=32.
- Sub-module `edge_rise`, with ports clk, rst, d, rise. It holds the reset-to-1 `prev` register and is instantiated three times.
- Everything else (FSM, divider, burst counter, cycle counter) lives in one module. Target size is 150-250 lines.

## Test plan
- Reset with `key_run` held high, then hold it 20 cycles -> no `cpu_en` pulse, `state_o`=0.
- Step edge at t0 -> `cpu_en` high only for t0..t1, `cycle_cnt`=1, state back to IDLE at t1. A step edge during STEP is ignored.
- Run edge with `RUN_DIV`=4, run for 40 cycles, then run edge -> 10 pulses with period 4, first at t0+4. `cpu_en`=0 after the stop edge, `cycle_cnt`=10.
- Burst with `BURST_N`=8, `RUN_DIV`=4 -> exactly 8 pulses, then IDLE. A second case aborts after the 3rd pulse with a run edge -> `cycle_cnt`=3, IDLE.
- `halt_i` asserted in the cycle a RUN pulse is due -> no pulse, `state_o`=4. Further key edges have no effect; `rst` returns to IDLE with `cycle_cnt`=0.
- Preload `cycle_cnt` near wrap (force to 32'hFFFF_FFFE), then issue 3 steps -> values FFFF_FFFF, 0, 1.
